// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and the
// slice-counter width helper.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of a counter that indexes nslice slices (never narrower than 1 bit).
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor. The requester drives
// start/A/B/Bin; the subtractor returns the handshake status and the
// registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borr;
    logic             Ovf;

    modport master (
        output start, A, B, Bin,
        input  ready, busy, done, Diff, Borr, Ovf
    );

    modport slave (
        input  start, A, B, Bin,
        output ready, busy, done, Diff, Borr, Ovf
    );
endinterface

// File: rtl/serial_subtractor_sub_slice.sv
// Combinational CHUNK-bit ripple subtractor built from full-subtractor cells:
// d = a - b - bin, bout = borrow out of the top cell.
module sub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);
    logic [CHUNK:0] brw;

    assign brw[0] = bin;

    // One full-subtractor cell per bit; borrow ripples upward.
    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        assign d[i]       = a[i] ^ b[i] ^ brw[i];
        assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign bout = brw[CHUNK];
endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: Diff = A - B - Bin, CHUNK bits per clock
// through a registered borrow chain, LSB slice first.
// Optional feature: define SERIAL_SUB_OVF_EN to compute the signed overflow
// flag; otherwise Ovf is tied to 0.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int              NSLICE = WIDTH / CHUNK;
    localparam int              CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0]   LAST   = CW'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             borr_q, borr_d;
    logic             done_q, done_d;
    logic             ready;
    logic [CHUNK-1:0] slice_d;
    logic             slice_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Ready is withheld during the done cycle so a start there is ignored.
    assign ready     = (state_q == IDLE) && !done_q;
    assign bus.ready = ready;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.Diff  = diff_q;
    assign bus.Borr  = borr_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.Ovf   = ovf_q;
`else
    assign bus.Ovf   = 1'b0;
`endif

    // Single slice subtractor, fed from the low end of the operand shift registers.
    sub_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .bin  (brw_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // Next-state and datapath update: accept in IDLE, one slice per RUN cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        borr_d  = borr_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && ready) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    brw_d   = bus.Bin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = bus.A[WIDTH-1];
                    b_msb_d = bus.B[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d = a_q >> CHUNK;
                b_d = b_q >> CHUNK;
                work_d[cnt_q * CHUNK +: CHUNK] = slice_d;
                brw_d = slice_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    diff_d  = work_d;
                    borr_d  = slice_bout;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (work_d[WIDTH-1] != a_msb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and visible outputs: synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            borr_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            borr_q  <= borr_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operand and working registers: fully loaded before use, so no reset needed.
    always_ff @(posedge clk) begin
        // NOTE: these datapath registers are deliberately unreset; they are written on accept before any read.
        a_q    <= a_d;
        b_q    <= b_d;
        work_q <= work_d;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_q <= a_msb_d;
        b_msb_q <= b_msb_d;
`endif
    end
endmodule
